// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel fetch path: display geometry, FSM encoding
// and the colour-bar palette used by the optional test-pattern build.
package vga_pkg;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned V_DISPLAY = 480;

    typedef logic [1:0] state_t;

    localparam state_t UNLOCKED = 2'd0;
    localparam state_t VBLANK   = 2'd1;
    localparam state_t ACTIVE   = 2'd2;
    localparam state_t HBLANK   = 2'd3;

    localparam int unsigned BAR_COUNT = 5;

    // RGB332 bars, index 0 leftmost: white, yellow, cyan, green, magenta.
    localparam logic [BAR_COUNT-1:0][7:0] BAR_PALETTE = {8'hE3, 8'h1C, 8'h1F, 8'hFC, 8'hFF};

    function automatic logic [7:0] bar_colour(input logic [2:0] idx);
        return (idx < 3'(BAR_COUNT)) ? BAR_PALETTE[idx] : 8'h00;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Parameterised-depth valid/data shift register used to align per-pixel
// side information with the RAM read data.
module vga_delay_line #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [DEPTH-1:0]        vld_q;
    logic [DEPTH-1:0][W-1:0] dat_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= valid_i;
            dat_q[0] <= data_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Frame-locked pixel fetcher: streams frame-buffer bytes to a blank-forced RGB output.
// Define VGA_TEST_PATTERN_EN to replace RAM data with colour bars indexed by x[9:7].
module vga_pixel_fetch #(
    parameter int unsigned H_DISPLAY = vga_pkg::H_DISPLAY,
    parameter int unsigned V_DISPLAY = vga_pkg::V_DISPLAY,
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned MEM_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              vDisplay,
    input  logic              hDisplay,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [9:0]        x,
    output logic [8:0]        y,
    output logic [7:0]        rgb,
    output logic              pix_valid,
    output logic              frame_start,
    output logic              timing_err
);

    import vga_pkg::*;

    localparam logic [9:0] X_MAX = 10'(H_DISPLAY);
    localparam logic [8:0] Y_MAX = 9'(V_DISPLAY);
`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned DL_W = 4;
`else
    localparam int unsigned DL_W = 1;
`endif

    logic              vs_q, vs_prev_q, vde_n_q, hde_n_q;
    state_t            state_q, state_d;
    logic [9:0]        col_q, col_d;
    logic [8:0]        row_q, row_d;
    logic [ADDR_W-1:0] acc_q, acc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic              mem_rd_q, frame_start_q, err_q, pix_valid_q;
    logic [7:0]        rgb_q, rgb_d;

    logic              act, slot, ovf, fetch;
    logic [DL_W-1:0]   dl_in, dl_out;
    logic              dl_valid;

    // Inputs are registered once; every decision below works on the registered copies.
    assign act   = !hde_n_q && !vde_n_q;
    assign slot  = (state_q != UNLOCKED) && act && !vs_q;
    assign ovf   = slot && (col_q == X_MAX || row_q == Y_MAX);
    assign fetch = slot && !ovf;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        acc_d   = acc_q;
        addr_d  = addr_q;
        x_d     = x_q;
        y_d     = y_q;
        if (vs_q) begin
            state_d = VBLANK;
            col_d   = '0;
            row_d   = '0;
            acc_d   = '0;
            x_d     = '0;
            y_d     = '0;
        end else begin
            unique case (state_q)
                UNLOCKED: ;
                VBLANK, HBLANK: if (act) state_d = ACTIVE;
                ACTIVE: if (!act) begin
                    state_d = HBLANK;
                    col_d   = '0;
                    if (row_q != Y_MAX) row_d = row_q + 9'd1;
                end
                default: ;
            endcase
            if (fetch) begin
                col_d  = col_q + 10'd1;
                acc_d  = acc_q + ADDR_W'(1);
                addr_d = acc_q;
                x_d    = col_q;
                y_d    = row_q;
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    assign dl_in = {fetch, col_q[9:7]};
`else
    assign dl_in = fetch;
`endif

    vga_delay_line #(
        .DEPTH(MEM_LAT + 1),
        .W    (DL_W)
    ) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid_i(slot),
        .data_i (dl_in),
        .valid_o(dl_valid),
        .data_o (dl_out)
    );

    // Overflow slots travel the delay line as valid-but-not-fetched and emit black.
    always_comb begin
        rgb_d = '0;
        if (dl_valid && dl_out[DL_W-1]) begin
`ifdef VGA_TEST_PATTERN_EN
            rgb_d = bar_colour(dl_out[2:0]);
`else
            rgb_d = mem_rdata;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_q          <= 1'b0;
            vs_prev_q     <= 1'b0;
            vde_n_q       <= 1'b1;
            hde_n_q       <= 1'b1;
            state_q       <= UNLOCKED;
            col_q         <= '0;
            row_q         <= '0;
            acc_q         <= '0;
            addr_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            mem_rd_q      <= 1'b0;
            frame_start_q <= 1'b0;
            err_q         <= 1'b0;
            rgb_q         <= '0;
            pix_valid_q   <= 1'b0;
        end else begin
            vs_q          <= vsync;
            vs_prev_q     <= vs_q;
            vde_n_q       <= vDisplay;
            hde_n_q       <= hDisplay;
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            acc_q         <= acc_d;
            addr_q        <= addr_d;
            x_q           <= x_d;
            y_q           <= y_d;
`ifdef VGA_TEST_PATTERN_EN
            mem_rd_q      <= 1'b0;
`else
            mem_rd_q      <= fetch;
`endif
            frame_start_q <= vs_q & ~vs_prev_q;
            err_q         <= err_q | ovf;
            rgb_q         <= rgb_d;
            pix_valid_q   <= dl_valid;
        end
    end

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = addr_q;
    assign x           = x_q;
    assign y           = y_q;
    assign rgb         = rgb_q;
    assign pix_valid   = pix_valid_q;
    assign frame_start = frame_start_q;
    assign timing_err  = err_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch: randomized frame timing driven against a
// frame-level reference model, with a separate monitor checking every DUT output.
module tb_vga_pixel_fetch;

    localparam int TB_H       = 640;
    localparam int TB_V       = 6;
    localparam int TB_MEM_LAT = 1;
    localparam int L          = TB_MEM_LAT + 2;
`ifdef VGA_TEST_PATTERN_EN
    localparam logic RD_EXP = 1'b0;
`else
    localparam logic RD_EXP = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst_n, vsync, vDisplay, hDisplay;
    logic        mem_rd;
    logic [18:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [7:0]  rgb;
    logic        pix_valid, frame_start, timing_err;

    vga_pixel_fetch #(
        .H_DISPLAY(TB_H),
        .V_DISPLAY(TB_V),
        .ADDR_W   (19),
        .MEM_LAT  (TB_MEM_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .vDisplay   (vDisplay),
        .hDisplay   (hDisplay),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .x          (x),
        .y          (y),
        .rgb        (rgb),
        .pix_valid  (pix_valid),
        .frame_start(frame_start),
        .timing_err (timing_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ram_byte(input int addr);
        logic [31:0] a;
        a = addr;
        return a[7:0] ^ a[15:8];
    endfunction

    // Frame-buffer RAM with TB_MEM_LAT cycles of read latency.
    logic [7:0] ram_p1 = 8'h00, ram_p2 = 8'h00;
    always @(posedge clk) begin
        if (mem_rd) ram_p1 <= ram_byte(int'(mem_addr));
        ram_p2 <= ram_p1;
    end
    assign mem_rdata = (TB_MEM_LAT == 2) ? ram_p2 : ram_p1;

    typedef struct { int due; int addr; int col; int row; } fetch_t;
    typedef struct { int due; logic [7:0] rgb; } pix_t;
    typedef struct { int due; logic val; } err_t;

    fetch_t fq[$];
    pix_t   pq[$];
    int     fsq[$];
    err_t   eq[$];

    int checks = 0;
    int fails  = 0;
    bit mon_en = 1'b0;
    logic exp_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pixel_of(input int addr, input int col);
`ifdef VGA_TEST_PATTERN_EN
        return vga_pkg::BAR_PALETTE[col / 128];
`else
        return (col >= 0) ? ram_byte(addr) : 8'h00;
`endif
    endfunction

    // Reference model: one call per input cycle, s = edge that samples the inputs.
    bit m_locked = 0, m_prev_vs = 0, m_in_line = 0;
    int m_addr = 0, m_col = 0, m_row = 0;

    task automatic model(input bit vs, input bit act, input int s);
        if (vs && !m_prev_vs) fsq.push_back(s + 1);
        m_prev_vs = vs;
        if (vs) begin
            m_locked = 1; m_addr = 0; m_col = 0; m_row = 0; m_in_line = 0;
        end else if (m_locked) begin
            if (act) begin
                if (m_col >= TB_H || m_row >= TB_V) begin
                    pq.push_back('{due: s + L, rgb: 8'h00});
                    eq.push_back('{due: s + 1, val: 1'b1});
                end else begin
                    fq.push_back('{due: s + 1, addr: m_addr, col: m_col, row: m_row});
                    pq.push_back('{due: s + L, rgb: pixel_of(m_addr, m_col)});
                    m_addr++;
                    m_col++;
                end
                m_in_line = 1;
            end else if (m_in_line) begin
                m_in_line = 0;
                m_col = 0;
                if (m_row < TB_V) m_row++;
            end
        end
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    always @(negedge clk) begin : monitor
        fetch_t f;
        pix_t   p;
        err_t   e;
        int     t;
        if (mon_en) begin
            while (eq.size() > 0 && eq[0].due <= cyc) begin
                e = eq.pop_front();
                exp_err = e.val;
            end
            chk("timing_err", timing_err, exp_err);

            if (fq.size() > 0 && fq[0].due == cyc) begin
                f = fq.pop_front();
                chk("mem_rd", mem_rd, RD_EXP);
                chk("mem_addr", mem_addr, f.addr);
                chk("x", x, f.col);
                chk("y", y, f.row);
            end else if (mem_rd) begin
                chk("mem_rd_spurious", mem_rd, 1'b0);
            end

            if (pq.size() > 0 && pq[0].due == cyc) begin
                p = pq.pop_front();
                chk("pix_valid", pix_valid, 1'b1);
                chk("rgb", rgb, p.rgb);
            end else if (pix_valid || rgb != 8'h00) begin
                chk("pix_valid_spurious", pix_valid, 1'b0);
                chk("rgb_blank", rgb, 8'h00);
            end

            if (fsq.size() > 0 && fsq[0] == cyc) begin
                t = fsq.pop_front();
                chk("frame_start", frame_start, 1'b1);
            end else if (frame_start) begin
                chk("frame_start_spurious", frame_start, 1'b0);
            end
        end
    end

    task automatic drive(input bit vs, input bit vde_n, input bit hde_n);
        vsync = vs;
        vDisplay = vde_n;
        hDisplay = hde_n;
        model(vs, !vde_n && !hde_n, cyc + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_rgb", rgb, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_timing_err", timing_err, 0);
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        vsync = 1'($urandom_range(0, 1));
        vDisplay = 1'b0;
        hDisplay = 1'b0;
        // Anything due at or after the reset edge is flushed by the reset.
        while (fq.size() > 0 && fq[$].due > cyc) void'(fq.pop_back());
        while (pq.size() > 0 && pq[$].due > cyc) void'(pq.pop_back());
        while (fsq.size() > 0 && fsq[$] > cyc) void'(fsq.pop_back());
        while (eq.size() > 0 && eq[$].due > cyc) void'(eq.pop_back());
        eq.push_back('{due: cyc + 1, val: 1'b0});
        m_locked = 0;
        m_prev_vs = 0;
        m_in_line = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        check_reset_outputs();
        rst_n = 1'b1;
        vsync = 1'b0;
        vDisplay = 1'b1;
        hDisplay = 1'b1;
    endtask

    task automatic vsync_pulse();
        repeat ($urandom_range(1, 3)) drive(1, 1, 1'($urandom_range(0, 1)));
        repeat ($urandom_range(2, 6)) drive(0, 1, 1'($urandom_range(0, 1)));
    endtask

    task automatic line(input int n_act);
        repeat (n_act) drive(0, 0, 0);
        repeat ($urandom_range(1, 8)) drive(0, 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        vsync = 1'b0;
        vDisplay = 1'b1;
        hDisplay = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Active timing before any vsync must be ignored.
        repeat (20) drive(0, 0, 0);
        drive(0, 1, 1);
        chk("unlocked_pix_valid", pix_valid, 0);

        // Clean full-width frame.
        vsync_pulse();
        for (int l = 0; l < TB_V; l++) line(TB_H);
        chk("last_addr", mem_addr, TB_H * TB_V - 1);

        // Ragged lines with a vsync landing on an active cycle.
        vsync_pulse();
        line($urandom_range(1, TB_H));
        repeat ($urandom_range(1, 50)) drive(0, 0, 0);
        drive(1, 0, 0);
        for (int l = 0; l < 3; l++) line($urandom_range(1, TB_H));
        chk("no_err_yet", timing_err, 0);

        // Column overflow on the second line, then a line past the last row.
        vsync_pulse();
        line(TB_H);
        repeat (TB_H + 1) drive(0, 0, 0);
        drive(0, 0, 1);
        chk("x_saturated", x, TB_H - 1);
        chk("err_set", timing_err, 1);
        for (int l = 2; l < TB_V; l++) line(TB_H);
        line($urandom_range(1, 20));

        // Error stays sticky across a new frame.
        vsync_pulse();
        line($urandom_range(1, TB_H));
        chk("err_sticky", timing_err, 1);

        // Reset mid-line, acts without vsync, then relock.
        vsync_pulse();
        repeat ($urandom_range(10, 200)) drive(0, 0, 0);
        apply_reset(1);
        repeat (30) drive(0, 0, 0);
        drive(0, 1, 1);
        vsync_pulse();
        for (int l = 0; l < 2; l++) line(TB_H);

        repeat (10) drive(0, 1, 1);
        chk("fetch_queue_drained", fq.size(), 0);
        chk("pix_queue_drained", pq.size(), 0);
        chk("fs_queue_drained", fsq.size(), 0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
